// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS instruction fetch stage. Owns the PC, runs a req/ack
//   handshake with instruction memory and holds one fetched word for decode.
// Latency: a word is presented (instr_valid=1) the cycle after its memory ack.
// Backpressure: stall holds the output word; fetching pauses (imem_req=0) in HOLD.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   imem_req/imem_addr     fetch request and byte address (stable until ack)
//   imem_ack/imem_rdata    memory response, same cycle as request or later
//   stall                  decode cannot consume the presented word
//   redirect_valid/_target branch/jump redirect pulse and new PC
//   instr_valid/instr      presented word (instr forced to 0 when not valid)
//   opcode                 instr[31:26] for the control unit
//   pc_out/pc_plus4        address of instr and that address + 4
// Option FETCH_ALIGN_CHECK_EN: adds fetch_fault; a misaligned redirect target
//   stops fetching until reset. Without it, target[1:0] are forced to 2'b00.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding (or about to issue)
    S_HOLD  = 2'd1,  // output word stalled, fetching paused
    S_KILL  = 2'd2   // draining a request made stale by a redirect
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_addr;     // address of the request on the bus
  logic [31:0] r_pc;       // next address to fetch
  logic        r_vld;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;

  logic        w_consume;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_next;
  logic        w_fault_nxt;  // fault state as it will be after this edge

  assign w_consume = r_vld & ~stall;
  assign w_tgt     = {redirect_target[31:2], 2'b00};
  assign w_pc_next = r_pc + PC_INC;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  assign w_fault_nxt = r_fault | (redirect_valid & (|redirect_target[1:0]));
  assign fetch_fault = r_fault;

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (w_fault_nxt) begin
      r_fault <= 1'b1;
    end
  end
`else
  logic w_unused_tgt_lsb;

  assign w_fault_nxt      = 1'b0;
  assign w_unused_tgt_lsb = ^redirect_target[1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
      r_pc     <= RESET_PC;
      r_vld    <= 1'b0;
      r_instr  <= 32'h0;
      r_pc_out <= 32'h0;
    end else if (redirect_valid) begin
      // Redirect beats everything: the held word is discarded even if stalled.
      r_vld   <= 1'b0;
      r_instr <= 32'h0;
      r_pc    <= w_tgt;
      if (r_req && !imem_ack) begin
        // Request still pending: keep it on the bus unchanged and drop its data.
        r_state <= S_KILL;
      end else begin
        // No request, or its ack is this cycle (data dropped): restart at target.
        r_state <= S_FETCH;
        r_req   <= ~w_fault_nxt;
        r_addr  <= w_tgt;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            // Idle after reset (or faulted): start requesting at the PC.
            r_req  <= ~w_fault_nxt;
            r_addr <= r_pc;
            if (w_consume) begin
              r_vld   <= 1'b0;
              r_instr <= 32'h0;
            end
          end else if (imem_ack) begin
            if (!r_vld || w_consume) begin
              // Register empty or being consumed: refill, keep streaming.
              r_vld    <= 1'b1;
              r_instr  <= imem_rdata;
              r_pc_out <= r_addr;
              r_pc     <= w_pc_next;
              r_addr   <= w_pc_next;
            end else begin
              // Register full and stalled: the returned word has nowhere to go.
              // Drop it without advancing the PC; it is refetched after the
              // held word is consumed, so nothing is lost or duplicated.
              r_state <= S_HOLD;
              r_req   <= 1'b0;
            end
          end else if (w_consume) begin
            r_vld   <= 1'b0;
            r_instr <= 32'h0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_vld   <= 1'b0;
            r_instr <= 32'h0;
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        S_KILL: begin
          // Output register is already empty here; wait for the stale ack.
          if (imem_ack) begin
            r_state <= S_FETCH;
            r_req   <= ~w_fault_nxt;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = r_vld;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign pc_out      = r_pc_out;
  assign pc_plus4    = r_pc_out + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .opcode          (opcode),
    .pc_out          (pc_out),
    .pc_plus4        (pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault     (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and scoreboard state.
  int          n_vec = 0;
  int          n_err = 0;
  int          n_consumed = 0;
  logic [31:0] exp_pc = 32'h0;    // address of the next word decode must see
  bit          chk_flush = 0;

  // Memory model state.
  bit          mem_busy = 0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = 32'h0;

  // Stimulus knobs.
  int          fixed_delay = 0;   // >=0: fixed ack delay, <0: random 0..max_delay
  int          max_delay = 0;
  int          stall_pct = 0;
  int          redir_pct = 0;
  bit          stall_force = 0;
  bit          force_redir = 0;
  logic [31:0] force_tgt = 32'h0;
  bit          allow_misalign = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: a function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2], a[27:2]};
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) == 0) rand_target = 32'hFFFF_FFF0 | {28'h0, r[3:0]};
    else                           rand_target = {22'h0, r[9:0]};
    if (!allow_misalign) rand_target[1:0] = 2'b00;
  endfunction

  // One clock cycle: sample at the falling edge, run the memory model,
  // drive stall/redirect, and score any word decode takes at the next edge.
  task automatic step();
    logic        ack_now;
    logic        rdv;
    logic [31:0] tgt;
    logic [31:0] w;
    @(negedge clk);
    if (chk_flush) check_eq("flush_vld", 32'(instr_valid), 32'd0);
    chk_flush = 0;
    if (!instr_valid) begin
      check_eq("empty_instr", instr, 32'h0);
      check_eq("empty_opcode", 32'(opcode), 32'd0);
    end

    ack_now = 1'b0;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_wait = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, max_delay));
        mem_addr = imem_addr;
      end else begin
        check_eq("addr_stable", imem_addr, mem_addr);
      end
      if (mem_wait == 0) begin
        ack_now  = 1'b1;
        mem_busy = 0;
      end else begin
        mem_wait--;
      end
    end else begin
      mem_busy = 0;
    end
    imem_ack   = ack_now;
    imem_rdata = ack_now ? mem_word(mem_addr) : $urandom;

    stall = stall_force ? 1'b1 : (int'($urandom_range(0, 99)) < stall_pct);

    if (force_redir) begin
      rdv = 1'b1;
      tgt = force_tgt;
      force_redir = 0;
    end else begin
      rdv = (int'($urandom_range(0, 99)) < redir_pct);
      tgt = rand_target();
    end
    redirect_valid  = rdv;
    redirect_target = rdv ? tgt : $urandom;

    if (rdv) begin
      exp_pc    = {tgt[31:2], 2'b00};
      chk_flush = 1;
    end else if (instr_valid && !stall) begin
      w = mem_word(exp_pc);
      check_eq("pc_out", pc_out, exp_pc);
      check_eq("instr", instr, w);
      check_eq("opcode", 32'(opcode), {26'h0, w[31:26]});
      check_eq("pc_plus4", pc_plus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    exp_pc    = 32'h0;
    mem_busy  = 0;
    chk_flush = 0;
  endtask

  initial begin
    int          base;
    logic [31:0] held;
    bit          found;

    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;

    // Reset values.
    apply_reset();
    repeat (3) step();
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_vld", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_opcode", 32'(opcode), 32'd0);
    check_eq("rst_pc_out", pc_out, 32'h0);
    check_eq("rst_pc_plus4", pc_plus4, 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("rst_fault", 32'(fetch_fault), 32'd0);
`endif
    rst_n = 1'b1;

    // Zero-wait memory, no stall: one instruction per cycle.
    fixed_delay = 0;
    repeat (3) step();
    base = n_consumed;
    repeat (20) step();
    check_eq("throughput", 32'(n_consumed - base), 32'd20);

    // Stall for three cycles: word held stable, fetching paused, then resumes.
    stall_force = 1;
    step();
    check_eq("stall_vld", 32'(instr_valid), 32'd1);
    held = instr;
    repeat (2) begin
      step();
      check_eq("hold_req", 32'(imem_req), 32'd0);
      check_eq("hold_instr", instr, held);
    end
    stall_force = 0;
    step();
    step();
    check_eq("resume_req", 32'(imem_req), 32'd1);

    // Memory ack two cycles after request.
    fixed_delay = 2;
    base = n_consumed;
    repeat (24) step();
    check_eq("slow_progress", 32'(n_consumed - base >= 6), 32'd1);

    // Random mix of delays, stalls and redirects.
`ifdef FETCH_ALIGN_CHECK_EN
    allow_misalign = 0;
`endif
    fixed_delay = -1;
    max_delay   = 3;
    stall_pct   = 30;
    redir_pct   = 6;
    base = n_consumed;
    repeat (3000) step();
    check_eq("rand_progress", 32'(n_consumed - base >= 200), 32'd1);

    // Misaligned redirect target.
    stall_pct   = 0;
    redir_pct   = 0;
    fixed_delay = 1;
    repeat (4) step();
    force_redir = 1;
    force_tgt   = 32'h0000_0042;
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    repeat (6) step();
    check_eq("fault_set", 32'(fetch_fault), 32'd1);
    check_eq("fault_req", 32'(imem_req), 32'd0);
    check_eq("fault_vld", 32'(instr_valid), 32'd0);
    apply_reset();
    #1;
    check_eq("fault_clear", 32'(fetch_fault), 32'd0);
    check_eq("fault_rst_req", 32'(imem_req), 32'd0);
    step();
    rst_n = 1'b1;
    base = n_consumed;
    repeat (12) step();
    check_eq("post_fault_progress", 32'(n_consumed - base >= 2), 32'd1);
`else
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instr_valid) found = 1;
    end
    check_eq("align_found", 32'(found), 32'd1);
    check_eq("align_pc", pc_out, 32'h0000_0040);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage of the MIPS datapath.
- Owns the PC, runs a request/acknowledge handshake with instruction memory, and holds one fetched word in an output register.
- Presents that word to decode/control with a valid/stall handshake; `opcode` drives the control unit's opcode input directly.
- Accepts branch/jump redirects from downstream and discards any in-flight fetch they make stale.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- PC_INC, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch byte address; equals the PC while imem_req=1.
- imem_ack  input  1  memory returns imem_rdata this cycle; may arrive in the same cycle as the request or later.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- stall  input  1  decode cannot consume this cycle.
- redirect_valid  input  1  single-cycle pulse: change fetch flow.
- redirect_target  input  32  new PC when redirect_valid=1.
- instr_valid  output  1  instr/opcode/pc_out hold a live instruction.
- instr  output  32  fetched instruction word.
- opcode  output  6  instr[31:26]; feeds the control unit.
- pc_out  output  32  address of instr.
- pc_plus4  output  32  pc_out + 4, for branch/link computation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: imem_req=0, instr_valid=0, instr=0, opcode=0, pc_out=0, pc_plus4=4.
  - Internal state: PC=RESET_PC, state=FETCH, kill flag=0.
- Empty output register: when instr_valid=0, instr is forced to 32'h0 (sll $0,$0,0). The control unit then decodes an R-type write to $zero, which is harmless.
- States:
  - FETCH: request outstanding.
  - HOLD: output register full, next fetch blocked.
  - KILL: draining a stale request.
- FETCH:
  - imem_req=1, imem_addr=PC. imem_addr must stay stable until ack.
  - On imem_ack with no redirect:
    - Latch instr=imem_rdata, pc_out=PC, instr_valid=1.
    - PC<=PC+PC_INC, with 32-bit wrap (32'hFFFF_FFFC+4 -> 0).
  - The next request issues in the following cycle only if the output register will be empty or consumed (instr_valid=0 or stall=0). Otherwise go to HOLD with imem_req=0.
- Consumption: instr_valid=1 && stall=0 at a clock edge consumes the word.
  - A fetch ack in the same cycle refills the register, so throughput is 1 instr/cycle with zero-wait memory.
  - With no refill, instr_valid falls to 0.
- HOLD:
  - imem_req=0.
  - When stall=0, the word is consumed and the block returns to FETCH.
- Redirect (redirect_valid=1), which has priority over every other event in the same cycle:
  - Next cycle: instr_valid=0 (held word discarded even if stall=1), PC<=redirect_target with bits[1:0] handled per the optional feature.
  - Stale request: if imem_req=1 and imem_ack=0 in the redirect cycle, go to KILL. imem_req stays 1 at the old address until ack, the returned data is dropped, then FETCH resumes at the new PC.
  - Same-cycle ack: if imem_ack=1 in the redirect cycle, that data is dropped and the block goes to FETCH directly.
  - A second redirect while in KILL overwrites the target; there is still exactly one drain.
- Reset mid-request: imem_req drops asynchronously. Memory must tolerate an abandoned request.
- Latency: a redirect or reset release produces its first valid instr at ack cycle + 1.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A redirect_target with bits[1:0]≠0 sets fetch_fault sticky until reset and stops fetching (imem_req=0, instr_valid=0).
  - An outstanding request is still drained first.
- Undefined: no port; redirect_target[1:0] are silently forced to 2'b00.

Test Plan:
- Release reset, RESET_PC=0, zero-wait memory returning addr>>2, stall=0 -> imem_addr 0,4,8,…; instr 0,1,2 on consecutive cycles; pc_plus4 = pc_out+4.
- Memory ack delayed 2 cycles -> imem_addr held at 0x8 for 3 cycles; instr_valid pulses once per ack.
- stall=1 for 3 cycles with instr 0x2008_0005 (addi) -> opcode 6'b001000 held stable, imem_req=0 in HOLD, fetch resumes the cycle stall drops, no word lost or duplicated.
- Redirect to 0x40 while the request to 0xC is pending (ack 2 cycles later) -> 0xC data dropped, next imem_addr=0x40, first valid pc_out=0x40.
- Redirect and ack in the same cycle -> acked word never valid; fetch at target next cycle.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x42 -> fetch_fault=1, imem_req stays 0 until rst_n pulse; without the macro, fetch at 0x40.
